// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the fetch FSM state enum, the default reset PC and the NOP encoding.
package ifu_pkg;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } ifu_state_e;

    localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
    localparam logic [31:0] INST_NOP     = 32'h0000_0013;

    function automatic logic [31:0] seq_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/ifu_perf_cnt.sv
// Delivered-instruction counter; wraps from 2^32-1 back to 0.
// Ports: clk_i, rst_i (sync, active-high), inc_i (count enable), cnt_o (count).
module ifu_perf_cnt
    import ifu_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        inc_i,
    output logic [31:0] cnt_o
);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: one outstanding imem request, holds the fetched word
// until decode consumes it; redirects override every transition.
// Ports: clk, rst (sync, active-high); imem_req_valid/ready, imem_addr;
// imem_rsp_valid/data; inst_valid/ready, instruction, inst_pc to decode;
// redirect_valid/pc from execute; fetch_misalign; perf_fetch_cnt.
// Optional macro IFU_PERF_CNT_EN enables the delivered-instruction counter;
// without it perf_fetch_cnt reads as zero.
module ifu
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] instruction,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_misalign,
    output logic [31:0] perf_fetch_cnt
);

    ifu_state_e  state_q;
    logic [31:0] pc_q;
    logic        drop_q;
    logic [31:0] instr_q;
    logic [31:0] inst_pc_q;

    logic        req_fire;
    logic        deliver;

    assign fetch_misalign = |pc_q[1:0];
    assign imem_addr      = pc_q;
    assign imem_req_valid = (state_q == ST_REQ) && !redirect_valid
                            && !fetch_misalign;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign inst_valid     = (state_q == ST_HOLD);
    assign deliver        = inst_valid && inst_ready;
    assign instruction    = instr_q;
    assign inst_pc        = inst_pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_REQ;
            pc_q      <= RESET_PC;
            drop_q    <= 1'b0;
            instr_q   <= INST_NOP;
            inst_pc_q <= RESET_PC;
        end else if (redirect_valid) begin
            pc_q <= redirect_pc;
            unique case (state_q)
                ST_REQ: state_q <= ST_REQ;
                ST_WAIT: begin
                    // A response in the same cycle is simply discarded;
                    // otherwise remember to discard the one still in flight.
                    if (imem_rsp_valid) begin
                        state_q <= ST_REQ;
                        drop_q  <= 1'b0;
                    end else begin
                        drop_q  <= 1'b1;
                    end
                end
                ST_HOLD: state_q <= ST_REQ;
                default: state_q <= ST_REQ;
            endcase
        end else begin
            unique case (state_q)
                ST_REQ: begin
                    if (req_fire) begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (drop_q) begin
                            drop_q  <= 1'b0;
                            state_q <= ST_REQ;
                        end else begin
                            instr_q   <= imem_rsp_data;
                            inst_pc_q <= pc_q;
                            state_q   <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (inst_ready) begin
                        pc_q    <= seq_pc(pc_q);
                        state_q <= ST_REQ;
                    end
                end
                default: state_q <= ST_REQ;
            endcase
        end
    end

`ifdef IFU_PERF_CNT_EN
    ifu_perf_cnt u_perf_cnt (
        .clk_i (clk),
        .rst_i (rst),
        .inc_i (deliver),
        .cnt_o (perf_fetch_cnt)
    );
`else
    logic unused_deliver;
    assign unused_deliver = deliver;
    assign perf_fetch_cnt = '0;
`endif

endmodule

// File: tb/tb_ifu.sv
// Bench for ifu: directed scenarios then random traffic, all checked against
// a transaction-level model of pc, outstanding request and held instruction.
module tb_ifu;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] instruction;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_misalign;
    logic [31:0] perf_fetch_cnt;

    ifu dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .instruction    (instruction),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_misalign (fetch_misalign),
        .perf_fetch_cnt (perf_fetch_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    // Reference model state
    bit          model_ok = 0;
    logic [31:0] m_pc;
    bit          m_out;
    logic [31:0] m_addr;
    bit          m_stale;
    bit          m_held;
    logic [31:0] m_hdata;
    logic [31:0] m_hpc;
    int unsigned m_cnt;
    bit          force_dead = 0;
    bit          spur = 0;
    bit          seen_dead = 0;
    logic [31:0] dq[$];
    int          dcyc[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] exp_perf();
`ifdef IFU_PERF_CNT_EN
        return m_cnt;
`else
        return 32'd0;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit rdy, input bit rsp,
                        input bit ird, input bit rdv,
                        input logic [31:0] rpc);
        bit acc;
        bit dlv;
        bit rspv;
        bit exp_req;
        @(negedge clk);
        rst            = r;
        imem_req_ready = rdy;
        inst_ready     = ird;
        redirect_valid = rdv;
        redirect_pc    = rpc;
        if (m_out && rsp) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = force_dead ? 32'hDEAD_BEEF : mem_word(m_addr);
        end else if (!m_out && spur && $urandom_range(0, 7) == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = $urandom;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        #1;
        cyc++;
        exp_req = !m_out && !m_held && !rdv && (m_pc[1:0] == 2'b00);
        if (model_ok) begin
            check("imem_addr", imem_addr, m_pc);
            check("misalign", 32'(fetch_misalign), 32'(m_pc[1:0] != 2'b00));
            check("inst_valid", 32'(inst_valid), 32'(m_held));
            check("req_valid", 32'(imem_req_valid), 32'(exp_req));
            check("perf", perf_fetch_cnt, exp_perf());
            if (m_held) begin
                check("instruction", instruction, m_hdata);
                check("inst_pc", inst_pc, m_hpc);
            end
        end
        acc  = exp_req && rdy;
        dlv  = m_held && ird;
        rspv = imem_rsp_valid;
        if (r) begin
            model_ok = 1;
            m_pc     = 32'h8000_0000;
            m_out    = 0;
            m_stale  = 0;
            m_held   = 0;
            m_cnt    = 0;
        end else if (model_ok) begin
            if (dlv) begin
                m_cnt++;
                dq.push_back(m_hpc);
                dcyc.push_back(cyc);
                if (m_hdata == 32'hDEAD_BEEF) seen_dead = 1;
            end
            if (rdv) begin
                m_pc   = rpc;
                m_held = 0;
                if (m_out) begin
                    if (rspv) begin
                        m_out   = 0;
                        m_stale = 0;
                    end else begin
                        m_stale = 1;
                    end
                end
            end else begin
                if (dlv) begin
                    m_pc   = m_pc + 32'd4;
                    m_held = 0;
                end
                if (m_out && rspv) begin
                    m_out = 0;
                    if (m_stale) begin
                        m_stale = 0;
                    end else begin
                        m_held  = 1;
                        m_hdata = imem_rsp_data;
                        m_hpc   = m_pc;
                    end
                end else if (acc) begin
                    m_out   = 1;
                    m_addr  = m_pc;
                    m_stale = 0;
                end
            end
        end
    endtask

    // Let the last step's clock edge pass and quiet the inputs.
    task automatic settle();
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        inst_ready     = 1'b0;
        imem_req_ready = 1'b0;
        #1;
    endtask

    logic [31:0] saved;

    initial begin
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        // Sequential fetch with single-cycle memory
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        dq.delete();
        dcyc.delete();
        for (int i = 0; i < 9; i++) step(0, 1, 1, 1, 0, 0);
        check("seq_n", dq.size(), 3);
        check("seq_pc0", dq[0], 32'h8000_0000);
        check("seq_pc1", dq[1], 32'h8000_0004);
        check("seq_pc2", dq[2], 32'h8000_0008);
        check("seq_gap1", dcyc[1] - dcyc[0], 3);
        check("seq_gap2", dcyc[2] - dcyc[1], 3);

        // Decode stall in HOLD
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0);
        saved = instruction;
        for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 0, 0);
        check("stall_instr", instruction, saved);
        check("stall_pc", inst_pc, 32'h8000_000C);
        step(0, 1, 1, 1, 0, 0);

        // Redirect while waiting; late response must be dropped
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 1, 32'h8000_0100);
        force_dead = 1;
        step(0, 0, 1, 0, 0, 0);
        force_dead = 0;
        settle();
        check("drop_addr", imem_addr, 32'h8000_0100);
        check("drop_valid", 32'(inst_valid), 32'd0);

        // Misaligned redirect stalls fetch until an aligned redirect
        step(0, 1, 1, 1, 1, 32'h8000_0102);
        settle();
        check("mis_flag", 32'(fetch_misalign), 32'd1);
        check("mis_req", 32'(imem_req_valid), 32'd0);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 0, 0);
        step(0, 1, 1, 1, 1, 32'h8000_0200);
        dq.delete();
        for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 0, 0);
        check("resume_pc", dq[0], 32'h8000_0200);

        // Reset while holding an instruction
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        settle();
        check("rst_valid", 32'(inst_valid), 32'd0);
        check("rst_instr", instruction, 32'h0000_0013);
        check("rst_addr", imem_addr, 32'h8000_0000);
        check("rst_ipc", inst_pc, 32'h8000_0000);

        // Ten delivered, two withdrawn
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 0, 0, 0, 0);
            step(0, 1, 1, 0, 0, 0);
            step(0, 1, 1, 1, 0, 0);
        end
        for (int i = 0; i < 2; i++) begin
            step(0, 1, 0, 0, 0, 0);
            step(0, 1, 1, 0, 0, 0);
            step(0, 1, 1, 0, 1, 32'h8000_0000);
        end
        settle();
`ifdef IFU_PERF_CNT_EN
        check("perf10", perf_fetch_cnt, 32'd10);
`else
        check("perf10", perf_fetch_cnt, 32'd0);
`endif

        // Random traffic
        spur = 1;
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] tgt;
            tgt = 32'h8000_0000 + ($urandom_range(0, 63) << 2);
            if ($urandom_range(0, 7) == 0) tgt = tgt + 32'd2;
            step($urandom_range(0, 299) == 0,
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 9) == 0,
                 tgt);
        end
        check("never_dead", 32'(seen_dead), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
